// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-size and FSM state encodings,
// the default bus wait limit and the alignment rule used by the stage.
package mem_stage_pkg;

  localparam int WAIT_MAX_DEFAULT = 255;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11   // decoded exactly like SIZE_WORD
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } mem_state_e;

  // An access is misaligned when its address is not a multiple of its size.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the pipeline and the little-endian data bus:
// byte enables and replicated write data for stores, lane extraction and
// sign/zero extension for loads. Purely combinational.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Lane selection for both directions, decoded from the access size.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    be        = 4'h0;
    wdata     = store_data;
    load_data = 32'h0;
    shifted   = rdata >> {addr_lo, 3'b000};
    case (mem_size_e'(size))
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'hF;
        wdata     = store_data;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the pipelined MIPS CPU: EX/MEM pipeline register plus a
// req/ack data-memory master. Stalls the upstream pipeline while a load or
// store is outstanding and gives up with a sticky bus error after WAIT_MAX
// unanswered request cycles.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [2:0]  ctrl_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  regw_addr_in,
  input  logic        wb_wen_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        valid,
  output logic [2:0]  ctrl_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] memdata_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  rd_out,
  output logic [4:0]  regw_addr_out,
  output logic        wb_wen_out,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  mem_state_e         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timed_out;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic [1:0]         size_q;
  logic               sext_q;
  logic [31:0]        store_data_q;
  logic               wb_wen_q;

  logic               access_q;
  logic               memop;
  logic               load;
  logic               next_memop;
  logic [3:0]         lane_be;
  logic [31:0]        load_data;

  // Status of the instruction held in the stage register.
  assign access_q  = valid & (mem_rd_q | mem_wr_q);
  assign misalign  = access_q & is_misaligned(mem_size_e'(size_q), alu_res_out[1:0]);
  assign memop     = access_q & ~misalign;
  assign mem_stall = memop & (state != ST_DONE);
  assign load      = en & ~mem_stall;

  // Whether the instruction about to be captured will need the bus.
  assign next_memop = valid_in & ~flush & (mem_rd | mem_wr)
                    & ~is_misaligned(mem_size_e'(mem_size), alu_res_in[1:0]);

  // Bus outputs come straight from held state so they stay stable until dm_ack.
  assign dm_req   = (state == ST_ACCESS);
  assign dm_we    = dm_req & mem_wr_q;
  assign dm_addr  = {alu_res_out[31:2], 2'b00};
  assign dm_be    = dm_req ? lane_be : 4'h0;

  // A store, a misaligned access or a timed-out load must not reach the register file.
  assign wb_wen_out = wb_wen_q & valid & ~misalign & ~timed_out & ~mem_wr_q;

  mem_lane_align u_lane_align (
    .size       (size_q),
    .sext       (sext_q),
    .addr_lo    (alu_res_out[1:0]),
    .store_data (store_data_q),
    .rdata      (dm_rdata),
    .be         (lane_be),
    .wdata      (dm_wdata),
    .load_data  (load_data)
  );

  // EX/MEM pipeline register: captures on advance, otherwise holds (flush included).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      valid         <= 1'b0;
      ctrl_out      <= '0;
      alu_res_out   <= '0;
      rt_out        <= '0;
      rd_out        <= '0;
      regw_addr_out <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      size_q        <= '0;
      sext_q        <= 1'b0;
      store_data_q  <= '0;
      wb_wen_q      <= 1'b0;
    end else if (load) begin
      valid         <= valid_in & ~flush;
      ctrl_out      <= ctrl_in;
      alu_res_out   <= alu_res_in;
      rt_out        <= rt_in;
      rd_out        <= rd_in;
      regw_addr_out <= regw_addr_in;
      mem_rd_q      <= mem_rd;
      mem_wr_q      <= mem_wr;
      size_q        <= mem_size;
      sext_q        <= mem_sext;
      store_data_q  <= store_data_in;
      wb_wen_q      <= wb_wen_in;
    end
  end

  // Access FSM: launch on capture, finish on dm_ack or after WAIT_MAX unanswered cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      timed_out   <= 1'b0;
      memdata_out <= '0;
      bus_err     <= 1'b0;
    end else if (load) begin
      state     <= next_memop ? ST_ACCESS : ST_IDLE;
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if (state == ST_ACCESS) begin
      if (dm_ack) begin
        state <= ST_DONE;
        if (mem_rd_q) memdata_out <= load_data;
      end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
        state       <= ST_DONE;
        timed_out   <= 1'b1;
        bus_err     <= 1'b1;
        memdata_out <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instruction streams checked against a per-instruction transaction model.
module tb_mem_stage;

  localparam int WAIT = 255;

  logic        clk, rst, en, flush, valid_in;
  logic [2:0]  ctrl_in;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_size;
  logic        mem_sext;
  logic [31:0] alu_res_in, store_data_in;
  logic [4:0]  rt_in, rd_in, regw_addr_in;
  logic        wb_wen_in;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        valid;
  logic [2:0]  ctrl_out;
  logic [31:0] alu_res_out, memdata_out;
  logic [4:0]  rt_out, rd_out, regw_addr_out;
  logic        wb_wen_out, mem_stall, misalign, bus_err;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_md = 32'h0;
  bit          model_berr = 1'b0;

  mem_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
    .ctrl_in(ctrl_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_sext(mem_sext), .alu_res_in(alu_res_in), .store_data_in(store_data_in),
    .rt_in(rt_in), .rd_in(rd_in), .regw_addr_in(regw_addr_in), .wb_wen_in(wb_wen_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .valid(valid), .ctrl_out(ctrl_out), .alu_res_out(alu_res_out),
    .memdata_out(memdata_out), .rt_out(rt_out), .rd_out(rd_out),
    .regw_addr_out(regw_addr_out), .wb_wen_out(wb_wen_out),
    .mem_stall(mem_stall), .misalign(misalign), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: arithmetic on access size in bytes ----
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit mis_f(input logic [1:0] sz, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [31:0] addr);
    int v;
    v = ((1 << nbytes(sz)) - 1) << int'(addr[1:0]);
    return v[3:0];
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] sdata);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sdata[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] sz, input bit sx,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v, mask;
    int bits;
    bits = 8 * nbytes(sz);
    v    = rdata >> (8 * int'(addr[1:0]));
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
    v    = v & mask;
    if (sx && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Random garbage on every upstream input; the stage must ignore it while holding.
  task automatic scramble();
    en            = 1'($urandom);
    flush         = 1'($urandom);
    valid_in      = 1'($urandom);
    mem_rd        = 1'($urandom);
    mem_wr        = ~mem_rd & 1'($urandom);
    mem_size      = 2'($urandom);
    mem_sext      = 1'($urandom);
    ctrl_in       = 3'($urandom);
    alu_res_in    = $urandom;
    store_data_in = $urandom;
    rt_in         = 5'($urandom);
    rd_in         = 5'($urandom);
    regw_addr_in  = 5'($urandom);
    wb_wen_in     = 1'($urandom);
  endtask

  // One instruction through the stage; called at a negedge with the stage free to advance.
  task automatic run_instr(input bit ld, input bit st, input logic [1:0] sz, input bit sx,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int delay,
                           input bit vin, input bit fl, input string tag);
    logic [2:0] c3;
    logic [4:0] rt5, rd5, rw5;
    bit         wbw, ev, acc, mis, mop;
    c3 = 3'($urandom); rt5 = 5'($urandom); rd5 = 5'($urandom); rw5 = 5'($urandom);
    wbw = ld ? 1'b1 : st ? 1'b0 : 1'($urandom);
    en = 1'b1; flush = fl; valid_in = vin; mem_rd = ld; mem_wr = st;
    mem_size = sz; mem_sext = sx; alu_res_in = addr; store_data_in = sdata;
    ctrl_in = c3; rt_in = rt5; rd_in = rd5; regw_addr_in = rw5; wb_wen_in = wbw;
    dm_ack = 1'b0;
    @(negedge clk);
    ev  = vin & ~fl;
    acc = ev & (ld | st);
    mis = acc & mis_f(sz, addr);
    mop = acc & ~mis;
    check({tag, "_valid"}, valid, ev);
    check({tag, "_alu"}, alu_res_out, addr);
    check({tag, "_ctrl"}, ctrl_out, c3);
    check({tag, "_ids"}, {rt_out, rd_out, regw_addr_out}, {rt5, rd5, rw5});
    check({tag, "_misalign"}, misalign, mis);
    if (mop) begin
      for (int c = 0; c <= delay; c++) begin
        check({tag, "_stall"}, mem_stall, 1'b1);
        check({tag, "_req"}, dm_req, 1'b1);
        check({tag, "_addr"}, dm_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, dm_be, be_f(sz, addr));
        check({tag, "_we"}, dm_we, st);
        if (st) check({tag, "_wdata"}, dm_wdata, wdata_f(sz, sdata));
        scramble();
        dm_ack   = (c == delay);
        dm_rdata = (c == delay) ? rdata : $urandom;
        @(negedge clk);
      end
      dm_ack = 1'b0;
      if (ld) model_md = load_f(sz, sx, addr, rdata);
    end else begin
      check({tag, "_stall"}, mem_stall, 1'b0);
      check({tag, "_req"}, dm_req, 1'b0);
      scramble();
    end
    en = 1'b0;
    if (!mop) @(negedge clk);
    check({tag, "_done_stall"}, mem_stall, 1'b0);
    check({tag, "_done_req"}, dm_req, 1'b0);
    check({tag, "_hold_alu"}, alu_res_out, addr);
    check({tag, "_hold_valid"}, valid, ev);
    check({tag, "_memdata"}, memdata_out, model_md);
    check({tag, "_wb_wen"}, wb_wen_out, wbw & ev & ~mis & ~st);
    check({tag, "_bus_err"}, bus_err, model_berr);
    if (mop && ld && delay > 0) begin
      dm_ack = 1'b1; dm_rdata = ~rdata;
      @(negedge clk);
      dm_ack = 1'b0;
      check({tag, "_ack_ignored"}, memdata_out, model_md);
    end
  endtask

  initial begin
    int          cnt;
    int          kind;
    logic [31:0] a;
    logic [1:0]  sz;

    rst = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
    scramble();
    en = 1'b1; valid_in = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_req", dm_req, 1'b0);
    check("rst_alu", alu_res_out, 32'h0);
    check("rst_memdata", memdata_out, 32'h0);
    check("rst_flags", {mem_stall, misalign, bus_err, wb_wen_out}, 4'h0);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);

    run_instr(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, "lw");
    run_instr(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 1, 0, "lb");
    run_instr(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, 1, 0, "lbu");
    run_instr(0, 1, 2'b01, 0, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 0, 1, 0, "sh");
    run_instr(1, 0, 2'b10, 0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 4, 1, 0, "lw_wait5");
    run_instr(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0, 32'h1111_1111, 0, 1, 0, "lw_mis");
    run_instr(1, 0, 2'b01, 1, 32'h0000_0302, 32'h0, 32'h9ABC_0000, 2, 1, 1, "lh_flush");
    run_instr(1, 0, 2'b11, 0, 32'h0000_0304, 32'h0, 32'h7654_3210, 0, 1, 0, "lw_sz3");

    // Bus timeout: no acknowledge at all.
    en = 1'b1; flush = 1'b0; valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
    mem_size = 2'b10; mem_sext = 1'b0; alu_res_in = 32'h0000_0400; wb_wen_in = 1'b1;
    dm_ack = 1'b0;
    @(negedge clk);
    en = 1'b0;
    cnt = 0;
    while (dm_req === 1'b1 && cnt < WAIT + 10) begin
      cnt++;
      @(negedge clk);
    end
    model_berr = 1'b1;
    model_md   = 32'h0;
    check("to_req_cycles", cnt, WAIT);
    check("to_bus_err", bus_err, 1'b1);
    check("to_memdata", memdata_out, 32'h0);
    check("to_wb_wen", wb_wen_out, 1'b0);
    check("to_stall", mem_stall, 1'b0);
    run_instr(1, 0, 2'b10, 0, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 1, 1, 0, "after_to");

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom);
      a    = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      run_instr(kind == 0, kind == 1, sz, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                "rnd");
    end

    // Asynchronous reset in the middle of an access.
    en = 1'b1; flush = 1'b0; valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
    mem_size = 2'b10; alu_res_in = 32'h0000_0600; wb_wen_in = 1'b1; dm_ack = 1'b0;
    @(negedge clk);
    en = 1'b0;
    check("mid_req", dm_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_req", dm_req, 1'b0);
    check("arst_valid", valid, 1'b0);
    check("arst_alu", alu_res_out, 32'h0);
    check("arst_memdata", memdata_out, 32'h0);
    check("arst_flags", {mem_stall, misalign, bus_err, wb_wen_out}, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    model_md = 32'h0;
    model_berr = 1'b0;
    @(negedge clk);
    run_instr(1, 0, 2'b01, 1, 32'h0000_0702, 32'h0, 32'hFFFE_0001, 0, 1, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
